// File: rtl/next_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_gen
// Description : Next-PC sequencer feeding the program counter register.
//               Every clock it selects the address the PC loads: sequential
//               fetch, relative branch, absolute jump through an internal
//               target LUT, stall hold or halt hold. It also owns the
//               IDLE/RUN/DONE run state and a saturating retired-instruction
//               counter.
// Ports       : clk, reset (async, active-low)
//               start                 - begin execution (IDLE/DONE only)
//               prog_ctr[D]           - current PC, fed back from PC register
//               stall, halt           - hold / halt current instruction
//               jump_abs, lut_idx     - absolute jump through LUT[lut_idx]
//               branch_en, rel_offset - relative branch, signed offset
//               lut_we/waddr/wdata    - synchronous LUT write port
//               target[D]             - next PC value (combinational)
//               running, done         - registered state flags
//               instr_cnt[CNT_W]      - retired-instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_gen #(
    parameter int             D          = 12,
    parameter int             LUT_W      = 5,
    parameter int             OFF_W      = 8,
    parameter logic [D-1:0]   START_ADDR = '0,
    parameter int             CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [D-1:0]      prog_ctr,
    input  logic              stall,
    input  logic              halt,
    input  logic              jump_abs,
    input  logic [LUT_W-1:0]  lut_idx,
    input  logic              branch_en,
    input  logic [OFF_W-1:0]  rel_offset,
    input  logic              lut_we,
    input  logic [LUT_W-1:0]  lut_waddr,
    input  logic [D-1:0]      lut_wdata,
    output logic [D-1:0]      target,
    output logic              running,
    output logic              done,
    output logic [CNT_W-1:0]  instr_cnt
);

    localparam int LUT_DEPTH = 2 ** LUT_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               running_q, running_d;
    logic               done_q, done_d;
    logic [D-1:0]       lut_q [LUT_DEPTH];
    logic [D-1:0]       lut_d [LUT_DEPTH];

    logic [D-1:0]       offset_ext;
    logic [D-1:0]       target_run;

    // Size cast of a signed operand sign-extends the offset to PC width.
    assign offset_ext = D'(signed'(rel_offset));

    // RUN-state target selection, highest priority first. Stall and halt
    // both hold the PC; the adders wrap naturally modulo 2**D.
    always_comb begin
        target_run = prog_ctr + D'(1);
        if (stall || halt) begin
            target_run = prog_ctr;
        end else if (jump_abs) begin
            target_run = lut_q[lut_idx];
        end else if (branch_en) begin
            target_run = prog_ctr + offset_ext;
        end
    end

    // Next-state, counter and target decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        target  = START_ADDR;

        unique case (state_q)
            ST_IDLE: begin
                target = START_ADDR;
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                target = target_run;
                if (!stall) begin
                    // The halt cycle itself retires an instruction.
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (halt) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Restart presents the start address in the start cycle so
                // the PC begins from it on entry to RUN.
                if (start) begin
                    target  = START_ADDR;
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    target  = prog_ctr;
                end
            end
            default: begin
                state_d = ST_IDLE;
                target  = START_ADDR;
            end
        endcase
    end

    // Flags are registered from the next state so they never glitch on a
    // multi-bit state transition.
    always_comb begin
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    // LUT write port: a write becomes visible to reads on the next cycle.
    always_comb begin
        for (int i = 0; i < LUT_DEPTH; i++) begin
            lut_d[i] = lut_q[i];
        end
        if (lut_we) begin
            lut_d[lut_waddr] = lut_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= lut_d[i];
            end
        end
    end

    assign running   = running_q;
    assign done      = done_q;
    assign instr_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_next_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_next_pc_gen
// Description : Self-checking bench for next_pc_gen: directed scenarios
//               followed by randomized traffic compared against a
//               behavioural model of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_next_pc_gen;

    localparam int D        = 12;
    localparam int LUT_W    = 5;
    localparam int OFF_W    = 8;
    localparam int CNT_W    = 10;
    localparam int PC_MOD   = 4096;
    localparam int CNT_MAX  = 1023;

    logic              clk;
    logic              reset;
    logic              start;
    logic [D-1:0]      prog_ctr;
    logic              stall;
    logic              halt;
    logic              jump_abs;
    logic [LUT_W-1:0]  lut_idx;
    logic              branch_en;
    logic [OFF_W-1:0]  rel_offset;
    logic              lut_we;
    logic [LUT_W-1:0]  lut_waddr;
    logic [D-1:0]      lut_wdata;
    logic [D-1:0]      target;
    logic              running;
    logic              done;
    logic [CNT_W-1:0]  instr_cnt;

    next_pc_gen #(
        .D          (D),
        .LUT_W      (LUT_W),
        .OFF_W      (OFF_W),
        .START_ADDR ('0),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .prog_ctr   (prog_ctr),
        .stall      (stall),
        .halt       (halt),
        .jump_abs   (jump_abs),
        .lut_idx    (lut_idx),
        .branch_en  (branch_en),
        .rel_offset (rel_offset),
        .lut_we     (lut_we),
        .lut_waddr  (lut_waddr),
        .lut_wdata  (lut_wdata),
        .target     (target),
        .running    (running),
        .done       (done),
        .instr_cnt  (instr_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    int m_mode;
    int m_cnt;
    int m_lut [32];
    bit pc_loop;

    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_cnt  = 0;
        for (int i = 0; i < 32; i++) m_lut[i] = 0;
    endtask

    function automatic int model_target();
        int pc;
        int off;
        pc  = int'(prog_ctr);
        off = int'(rel_offset);
        if (off > 127) off = off - 256;
        if (m_mode == M_IDLE) return 0;
        if (m_mode == M_DONE) return start ? 0 : pc;
        if (stall || halt) return pc;
        if (jump_abs) return m_lut[lut_idx];
        if (branch_en) return (pc + off + PC_MOD) % PC_MOD;
        return (pc + 1) % PC_MOD;
    endfunction

    // Inputs are already set; compare outputs, then advance one clock.
    task automatic cycle();
        int exp_t;
        #1;
        exp_t = model_target();
        check_eq("target",  32'(target),    32'(exp_t));
        check_eq("running", 32'(running),   32'(m_mode == M_RUN));
        check_eq("done",    32'(done),      32'(m_mode == M_DONE));
        check_eq("cnt",     32'(instr_cnt), 32'(m_cnt));
        @(posedge clk);
        case (m_mode)
            M_IDLE: if (start) begin m_mode = M_RUN; m_cnt = 0; end
            M_RUN: if (!stall) begin
                if (m_cnt < CNT_MAX) m_cnt++;
                if (halt) m_mode = M_DONE;
            end
            default: if (start) begin m_mode = M_RUN; m_cnt = 0; end
        endcase
        if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
        @(negedge clk);
        if (pc_loop) prog_ctr = D'(exp_t);
    endtask

    task automatic idle_inputs();
        start = 0; stall = 0; halt = 0; jump_abs = 0; lut_idx = '0;
        branch_en = 0; rel_offset = '0; lut_we = 0; lut_waddr = '0;
        lut_wdata = '0;
    endtask

    int saved_cnt;

    initial begin
        n_checks = 0;
        n_errors = 0;
        pc_loop  = 0;
        prog_ctr = '0;
        idle_inputs();
        model_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        #1;
        check_eq("rst_target",  32'(target),    32'h0);
        check_eq("rst_running", 32'(running),   32'h0);
        check_eq("rst_done",    32'(done),      32'h0);
        check_eq("rst_cnt",     32'(instr_cnt), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        cycle();

        // Sequential fetch with the PC register closed in a loop.
        start = 1; pc_loop = 1;
        #1 check_eq("seq0", 32'(target), 32'h0);
        cycle();
        start = 0;
        for (int i = 1; i <= 3; i++) begin
            #1 check_eq("seq", 32'(target), 32'(i));
            cycle();
        end
        check_eq("cnt3", 32'(instr_cnt), 32'd3);
        check_eq("run1", 32'(running), 32'd1);
        pc_loop = 0;

        // LUT write then absolute jump.
        lut_we = 1; lut_waddr = 5; lut_wdata = 12'h3A0;
        cycle();
        lut_we = 0; prog_ctr = 12'h010; jump_abs = 1; lut_idx = 5;
        #1 check_eq("jump", 32'(target), 32'h3A0);
        cycle();
        jump_abs = 0;

        // Relative branches with wrap.
        branch_en = 1; prog_ctr = 12'h002; rel_offset = 8'hFC;
        #1 check_eq("br_neg", 32'(target), 32'hFFE);
        cycle();
        prog_ctr = 12'hFF0; rel_offset = 8'h7F;
        #1 check_eq("br_pos", 32'(target), 32'h06F);
        cycle();
        branch_en = 0;

        // Stall dominates halt and jump.
        prog_ctr = 12'h020; stall = 1; halt = 1; jump_abs = 1;
        saved_cnt = int'(instr_cnt);
        #1 check_eq("stall_t", 32'(target), 32'h020);
        cycle();
        check_eq("stall_cnt", 32'(instr_cnt), 32'(saved_cnt));
        check_eq("stall_run", 32'(running), 32'd1);
        stall = 0; jump_abs = 0;
        cycle();
        halt = 0;
        check_eq("halt_done", 32'(done), 32'd1);
        check_eq("halt_cnt", 32'(instr_cnt), 32'(saved_cnt + 1));

        // DONE holds the PC, restart presents the start address.
        prog_ctr = 12'h021;
        for (int i = 0; i < 10; i++) begin
            #1 check_eq("done_hold", 32'(target), 32'h021);
            cycle();
        end
        start = 1;
        #1 check_eq("restart_t", 32'(target), 32'h000);
        cycle();
        start = 0;
        check_eq("restart_run", 32'(running), 32'd1);
        check_eq("restart_cnt", 32'(instr_cnt), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            start      = ($urandom_range(0, 7) == 0);
            stall      = ($urandom_range(0, 4) == 0);
            halt       = ($urandom_range(0, 15) == 0);
            jump_abs   = ($urandom_range(0, 4) == 0);
            branch_en  = ($urandom_range(0, 2) == 0);
            lut_idx    = LUT_W'($urandom);
            rel_offset = OFF_W'($urandom);
            lut_we     = ($urandom_range(0, 3) == 0);
            lut_waddr  = ($urandom_range(0, 1) == 0) ? lut_idx : LUT_W'($urandom);
            lut_wdata  = D'($urandom);
            prog_ctr   = ($urandom_range(0, 7) == 0) ? 12'hFFF : D'($urandom);
            cycle();
        end
        idle_inputs();

        // Long unstalled run to reach counter saturation.
        if (m_mode != M_RUN) begin
            start = 1;
            cycle();
            start = 0;
        end
        pc_loop = 1;
        for (int i = 0; i < CNT_MAX + 8; i++) cycle();
        check_eq("cnt_sat", 32'(instr_cnt), 32'(CNT_MAX));
        pc_loop = 0;

        // Make sure LUT[5] is nonzero, then reset asynchronously mid-RUN.
        lut_we = 1; lut_waddr = 5; lut_wdata = 12'h3A0;
        cycle();
        lut_we = 0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_eq("arst_target",  32'(target),    32'h0);
        check_eq("arst_running", 32'(running),   32'h0);
        check_eq("arst_done",    32'(done),      32'h0);
        check_eq("arst_cnt",     32'(instr_cnt), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        start = 1;
        cycle();
        start = 0; jump_abs = 1; lut_idx = 5; prog_ctr = 12'h100;
        #1 check_eq("arst_lut5", 32'(target), 32'h0);
        cycle();
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
